// File: rtl/vcve2_pkg.sv
// Shared types for the vector register file arbiter: FSM states and requester ids.
package vcve2_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } vrf_arb_state_e;

  typedef enum logic {
    VRF_ARB_EXE = 1'b0,
    VRF_ARB_LSU = 1'b1
  } vrf_arb_id_e;

  // The round-robin pointer always hands priority to the requester that did not just finish.
  function automatic vrf_arb_id_e vrf_arb_other(input vrf_arb_id_e id);
    vrf_arb_other = (id == VRF_ARB_EXE) ? VRF_ARB_LSU : VRF_ARB_EXE;
  endfunction

endpackage

// File: rtl/vrf_arbiter.sv
// Round-robin arbiter in front of the single-port VRF RAM; locks ownership for
// multi-beat register-group bursts and flags bursts that exceed MaxBeats.
module vrf_arbiter
  import vcve2_pkg::*;
#(
  parameter int unsigned VLEN      = 128,
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned MaxBeats  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 exe_req_i,
  input  logic                 exe_we_i,
  input  logic [AddrWidth-1:0] exe_addr_i,
  input  logic [VLEN-1:0]      exe_wdata_i,
  input  logic                 exe_last_i,
  output logic                 exe_gnt_o,
  output logic                 exe_rvalid_o,
  output logic [VLEN-1:0]      exe_rdata_o,
  input  logic                 lsu_req_i,
  input  logic                 lsu_we_i,
  input  logic [AddrWidth-1:0] lsu_addr_i,
  input  logic [VLEN-1:0]      lsu_wdata_i,
  input  logic                 lsu_last_i,
  output logic                 lsu_gnt_o,
  output logic                 lsu_rvalid_o,
  output logic [VLEN-1:0]      lsu_rdata_o,
  output logic                 ram_req_o,
  output logic                 ram_we_o,
  output logic [AddrWidth-1:0] ram_addr_o,
  output logic [VLEN-1:0]      ram_wdata_o,
  input  logic [VLEN-1:0]      ram_rdata_i,
  output logic                 err_o
);

  localparam int unsigned CntW = $clog2(MaxBeats + 1);

  logic [1:0]           req_s;
  logic [1:0]           we_s;
  logic [1:0]           last_s;
  logic [AddrWidth-1:0] addr_s  [2];
  logic [VLEN-1:0]      wdata_s [2];
  logic [1:0]           gnt_s;
  logic [1:0]           rvalid_s;
  logic [VLEN-1:0]      rdata_s [2];
  logic                 acc_s;
  vrf_arb_id_e          win_s;
  logic [CntW-1:0]      cnt_inc_s;
  logic                 err_s;

  vrf_arb_state_e       state_q, state_d;
  vrf_arb_id_e          ptr_q, ptr_d;
  vrf_arb_id_e          owner_q, owner_d;
  logic [CntW-1:0]      beat_cnt_q, beat_cnt_d;
  logic                 rd_pend_q, rd_pend_d;
  vrf_arb_id_e          rd_owner_q, rd_owner_d;

  assign req_s      = {lsu_req_i, exe_req_i};
  assign we_s       = {lsu_we_i, exe_we_i};
  assign last_s     = {lsu_last_i, exe_last_i};
  assign addr_s[0]  = exe_addr_i;
  assign addr_s[1]  = lsu_addr_i;
  assign wdata_s[0] = exe_wdata_i;
  assign wdata_s[1] = lsu_wdata_i;

  // Grant selection; held off while reset is asserted so no beat leaks through.
  always_comb begin
    gnt_s = 2'b00;
    if (!rst_ni) begin
      gnt_s = 2'b00;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (req_s == 2'b11) begin
            gnt_s[ptr_q] = 1'b1;
          end else begin
            gnt_s = req_s;
          end
        end
        ARB_LOCK: gnt_s[owner_q] = req_s[owner_q];
        default:  gnt_s = 2'b00;
      endcase
    end
  end

  assign acc_s     = |gnt_s;
  assign win_s     = gnt_s[1] ? VRF_ARB_LSU : VRF_ARB_EXE;
  // The opening beat of a burst counts as one; in LOCK the winner is always the owner.
  assign cnt_inc_s = (state_q == ARB_LOCK) ? (beat_cnt_q + {{(CntW-1){1'b0}}, 1'b1})
                                           : {{(CntW-1){1'b0}}, 1'b1};

  // Next-state: a last beat or a full burst releases, anything else (re)locks.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    err_s      = 1'b0;
    if (acc_s) begin
      if (last_s[win_s]) begin
        state_d    = ARB_IDLE;
        ptr_d      = vrf_arb_other(win_s);
        beat_cnt_d = {CntW{1'b0}};
      end else if (cnt_inc_s == CntW'(MaxBeats)) begin
        state_d    = ARB_IDLE;
        ptr_d      = vrf_arb_other(win_s);
        beat_cnt_d = {CntW{1'b0}};
        err_s      = 1'b1;
      end else begin
        state_d    = ARB_LOCK;
        owner_d    = win_s;
        beat_cnt_d = cnt_inc_s;
      end
    end else begin
      state_d = state_q;
    end
  end

  // RAM port mux and read-response bookkeeping.
  always_comb begin
    ram_req_o   = acc_s;
    ram_we_o    = 1'b0;
    ram_addr_o  = {AddrWidth{1'b0}};
    ram_wdata_o = {VLEN{1'b0}};
    rd_pend_d   = 1'b0;
    rd_owner_d  = win_s;
    if (acc_s) begin
      ram_we_o    = we_s[win_s];
      ram_addr_o  = addr_s[win_s];
      ram_wdata_o = wdata_s[win_s];
      rd_pend_d   = ~we_s[win_s];
    end else begin
      ram_we_o  = 1'b0;
      rd_pend_d = 1'b0;
    end
  end

  assign err_o = err_s;

  // Arbitration and read-pending state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= VRF_ARB_EXE;
      owner_q    <= VRF_ARB_EXE;
      beat_cnt_q <= {CntW{1'b0}};
      rd_pend_q  <= 1'b0;
      rd_owner_q <= VRF_ARB_EXE;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_resp
    localparam vrf_arb_id_e Id = vrf_arb_id_e'(g);
    assign rvalid_s[g] = rd_pend_q && (rd_owner_q == Id);
    assign rdata_s[g]  = rvalid_s[g] ? ram_rdata_i : {VLEN{1'b0}};
  end

  assign exe_gnt_o    = gnt_s[0];
  assign lsu_gnt_o    = gnt_s[1];
  assign exe_rvalid_o = rvalid_s[0];
  assign lsu_rvalid_o = rvalid_s[1];
  assign exe_rdata_o  = rdata_s[0];
  assign lsu_rdata_o  = rdata_s[1];

endmodule

// File: tb/tb_vrf_arbiter.sv
// Self-checking bench for vrf_arbiter: directed scenarios then randomized bursts,
// all compared against a behavioural arbitration and RAM model.
module tb_vrf_arbiter;

  localparam int VLEN = 128;
  localparam int AW   = 5;
  localparam int MAXB = 8;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            exe_req_i = 1'b0, exe_we_i = 1'b0, exe_last_i = 1'b0;
  logic [AW-1:0]   exe_addr_i = '0;
  logic [VLEN-1:0] exe_wdata_i = '0;
  logic            lsu_req_i = 1'b0, lsu_we_i = 1'b0, lsu_last_i = 1'b0;
  logic [AW-1:0]   lsu_addr_i = '0;
  logic [VLEN-1:0] lsu_wdata_i = '0;
  logic            exe_gnt_o, exe_rvalid_o, lsu_gnt_o, lsu_rvalid_o;
  logic [VLEN-1:0] exe_rdata_o, lsu_rdata_o;
  logic            ram_req_o, ram_we_o, err_o;
  logic [AW-1:0]   ram_addr_o;
  logic [VLEN-1:0] ram_wdata_o;
  logic [VLEN-1:0] ram_rdata = '0;

  vrf_arbiter #(.VLEN(VLEN), .AddrWidth(AW), .MaxBeats(MAXB)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .exe_req_i(exe_req_i), .exe_we_i(exe_we_i), .exe_addr_i(exe_addr_i),
    .exe_wdata_i(exe_wdata_i), .exe_last_i(exe_last_i), .exe_gnt_o(exe_gnt_o),
    .exe_rvalid_o(exe_rvalid_o), .exe_rdata_o(exe_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_last_i(lsu_last_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency, driven by the DUT.
  logic [VLEN-1:0] mem [32];
  always @(posedge clk) begin
    if (ram_req_o) begin
      if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
      else          ram_rdata <= mem[ram_addr_o];
    end
  end

  // Reference model state.
  logic [VLEN-1:0] model_mem [32];
  bit              m_locked, m_owner, m_ptr, m_pend, m_pend_who;
  int              m_cnt;
  logic [VLEN-1:0] m_pend_data;
  int              m_win;

  int n_cmp = 0;
  int n_err = 0;
  logic            obs_eg, obs_lg, obs_err, obs_erv;
  logic [AW-1:0]   obs_addr;
  logic [VLEN-1:0] obs_erd;

  function automatic logic [VLEN-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_pend = 0; m_pend_who = 0; m_cnt = 0; m_win = -1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    exe_req_i = 1'b0; lsu_req_i = 1'b0;
    #1;
    chk("rst_exe_gnt", exe_gnt_o, 0);    chk("rst_lsu_gnt", lsu_gnt_o, 0);
    chk("rst_exe_rvalid", exe_rvalid_o, 0); chk("rst_lsu_rvalid", lsu_rvalid_o, 0);
    chk("rst_exe_rdata", exe_rdata_o, 0); chk("rst_lsu_rdata", lsu_rdata_o, 0);
    chk("rst_ram_req", ram_req_o, 0);    chk("rst_ram_we", ram_we_o, 0);
    chk("rst_ram_addr", ram_addr_o, 0);  chk("rst_err", err_o, 0);
    model_reset();
    @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  // One clock cycle: drive inputs, predict, check away from the edge, advance the model.
  task automatic cyc(input bit er, input bit ew, input logic [AW-1:0] ea, input bit el,
                     input bit lr, input bit lw, input logic [AW-1:0] la, input bit ll);
    bit r [2], we [2], lst [2];
    logic [AW-1:0] ad [2];
    logic [VLEN-1:0] wd [2];
    int w, beats;
    bit exp_err;
    r = '{er, lr}; we = '{ew, lw}; lst = '{el, ll}; ad = '{ea, la};
    wd = '{rand128(), rand128()};
    exe_req_i = er; exe_we_i = ew; exe_addr_i = ea; exe_last_i = el; exe_wdata_i = wd[0];
    lsu_req_i = lr; lsu_we_i = lw; lsu_addr_i = la; lsu_last_i = ll; lsu_wdata_i = wd[1];
    w = -1;
    if (!m_locked) begin
      if (er && lr) w = int'(m_ptr);
      else if (er)  w = 0;
      else if (lr)  w = 1;
    end else if (r[m_owner]) begin
      w = int'(m_owner);
    end
    beats = m_locked ? m_cnt + 1 : 1;
    exp_err = (w >= 0) && !lst[w] && (beats == MAXB);
    @(negedge clk);
    obs_eg = exe_gnt_o; obs_lg = lsu_gnt_o; obs_err = err_o; obs_addr = ram_addr_o;
    obs_erv = exe_rvalid_o; obs_erd = exe_rdata_o;
    chk("exe_gnt", exe_gnt_o, (w == 0));
    chk("lsu_gnt", lsu_gnt_o, (w == 1));
    chk("ram_req", ram_req_o, (w >= 0));
    chk("ram_we", ram_we_o, (w >= 0) ? we[w] : 1'b0);
    chk("ram_addr", ram_addr_o, (w >= 0) ? ad[w] : '0);
    chk("ram_wdata", ram_wdata_o, (w >= 0) ? wd[w] : '0);
    chk("err", err_o, exp_err);
    chk("exe_rvalid", exe_rvalid_o, m_pend && !m_pend_who);
    chk("lsu_rvalid", lsu_rvalid_o, m_pend && m_pend_who);
    chk("exe_rdata", exe_rdata_o, (m_pend && !m_pend_who) ? m_pend_data : '0);
    chk("lsu_rdata", lsu_rdata_o, (m_pend && m_pend_who) ? m_pend_data : '0);
    m_pend = 0;
    m_win = w;
    if (w >= 0) begin
      if (we[w]) model_mem[ad[w]] = wd[w];
      else begin m_pend = 1; m_pend_who = w[0]; m_pend_data = model_mem[ad[w]]; end
      if (lst[w] || beats == MAXB) begin
        m_locked = 0; m_cnt = 0; m_ptr = !w[0];
      end else begin
        m_locked = 1; m_owner = w[0]; m_cnt = beats;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int rem [2];
    bit rq [2];
    for (int i = 0; i < 32; i++) begin
      mem[i] = rand128();
      model_mem[i] = mem[i];
    end
    model_reset();
    do_reset();

    // Single read from EXE.
    cyc(1, 0, 5'd3, 1, 0, 0, 5'd0, 0);
    chk("sr_gnt", obs_eg, 1); chk("sr_addr", obs_addr, 5'd3);
    cyc(0, 0, 5'd0, 0, 0, 0, 5'd0, 0);
    chk("sr_rvalid", obs_erv, 1); chk("sr_rdata", obs_erd, model_mem[3]);

    // Contention from reset alternates EXE, LSU, EXE, LSU.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 5'(i), 1, 1, 0, 5'(i + 16), 1);
      chk("cont_exe", obs_eg, (i % 2 == 0)); chk("cont_lsu", obs_lg, (i % 2 == 1));
    end

    // LSU 4-beat write burst holds off EXE.
    do_reset();
    cyc(0, 0, 5'd0, 0, 1, 1, 5'd8, 0);
    chk("lock_first", obs_lg, 1);
    for (int k = 1; k < 4; k++) begin
      cyc(1, 0, 5'd1, 1, 1, 1, 5'(8 + k), (k == 3));
      chk("lock_exe_held", obs_eg, 0); chk("lock_lsu_beat", obs_lg, 1);
    end
    cyc(1, 0, 5'd1, 1, 0, 0, 5'd0, 0);
    chk("lock_exe_after", obs_eg, 1);

    // Gaps inside an EXE burst do not release the lock.
    do_reset();
    cyc(1, 0, 5'd2, 0, 1, 0, 5'd4, 1);
    chk("gap_first", obs_eg, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 5'd0, 0, 1, 0, 5'd4, 1);
      chk("gap_lsu_held", obs_lg, 0);
    end
    cyc(1, 1, 5'd2, 1, 1, 0, 5'd4, 1);
    chk("gap_last", obs_eg, 1);
    cyc(0, 0, 5'd0, 0, 1, 0, 5'd4, 1);
    chk("gap_lsu_after", obs_lg, 1);

    // Overrun: eight EXE beats without last.
    do_reset();
    for (int b = 0; b < MAXB; b++) begin
      cyc(1, 1, 5'(b), 0, (b > 0), 0, 5'd20, 1);
      chk("ovr_err", obs_err, (b == MAXB - 1)); chk("ovr_lsu_held", obs_lg, 0);
    end
    cyc(1, 1, 5'd0, 0, 1, 0, 5'd20, 1);
    chk("ovr_lsu_after", obs_lg, 1); chk("ovr_err_clear", obs_err, 0);

    // Reset mid-burst with a read pending.
    do_reset();
    cyc(1, 0, 5'd5, 0, 0, 0, 5'd0, 0);
    do_reset();
    cyc(1, 0, 5'd6, 1, 1, 0, 5'd7, 1);
    chk("mrst_exe_first", obs_eg, 1); chk("mrst_no_rvalid", obs_erv, 0);
    do_reset();
    cyc(0, 0, 5'd0, 0, 1, 0, 5'd7, 1);
    chk("mrst_lsu_gnt", obs_lg, 1);

    // Randomized bursts of 1..10 beats with occasional resets.
    rem = '{0, 0};
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 2) == 0) rem[i] = int'($urandom_range(1, 10));
        rq[i] = (rem[i] > 0) && ($urandom_range(0, 3) != 0);
      end
      cyc(rq[0], 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), (rem[0] == 1),
          rq[1], 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), (rem[1] == 1));
      if (m_win >= 0) rem[m_win] = rem[m_win] - 1;
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
        rem = '{0, 0};
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
